// File: rtl/add_sub_pkg.sv
// Shared constants and helpers for the pipelined adder-subtractor.
package add_sub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int unsigned MaxWidth = 64;

  // Signed limit of a 'width'-bit value: most negative when neg=1, else most positive.
  function automatic logic [MaxWidth-1:0] signed_limit(int unsigned width, logic neg);
    logic [MaxWidth-1:0] lim;
    lim = '0;
    for (int unsigned i = 0; i < MaxWidth; i++) begin
      if (i + 1 < width) begin
        lim[i] = ~neg;
      end else if (i + 1 == width) begin
        lim[i] = neg;
      end
    end
    return lim;
  endfunction

endpackage

// File: rtl/add_sub_chunk.sv
// Combinational CHUNK-bit add/subtract slice; B is inverted when sel selects SUB.
module add_sub_chunk
  import add_sub_pkg::*;
#(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             cin_i,
  input  logic             sel_i,
  output logic [CHUNK-1:0] s_o,
  output logic             cout_o
);

  logic [CHUNK-1:0] b_eff;

  assign b_eff = (sel_i == OP_SUB) ? ~b_i : b_i;
  assign {cout_o, s_o} = {1'b0, a_i} + {1'b0, b_eff} + {{CHUNK{1'b0}}, cin_i};

endmodule

// File: rtl/add_sub_pipe.sv
// Carry-pipelined adder-subtractor with valid/ready handshake on both sides.
// Define ADD_SUB_SAT_EN to saturate the result on signed overflow.
module add_sub_pipe
  import add_sub_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf,
  output logic             Zero
);

  localparam int unsigned CHUNK = WIDTH / STAGES;
  localparam int unsigned NPIPE = (STAGES > 1) ? STAGES - 1 : 1;
  localparam int unsigned LAST  = STAGES - 1;

  // Intermediate stage registers (stage LAST lands in the output registers)
  logic [NPIPE-1:0] vld_q, sel_q, c_q;
  logic [WIDTH-1:0] a_q [NPIPE];
  logic [WIDTH-1:0] b_q [NPIPE];
  logic [WIDTH-1:0] s_q [NPIPE];

  logic [STAGES-1:0] vld_in, sel_in, c_in, ch_c;
  logic [WIDTH-1:0]  a_in [STAGES];
  logic [WIDTH-1:0]  b_in [STAGES];
  logic [WIDTH-1:0]  s_in [STAGES];
  logic [WIDTH-1:0]  s_d  [STAGES];
  logic [CHUNK-1:0]  ch_s [STAGES];

  logic             out_valid_q, cout_q, ovf_q, zero_q;
  logic [WIDTH-1:0] sum_q;

  logic             stall;
  logic             a_msb, bp_msb, ovf_d;
  logic [WIDTH-1:0] res_d;

  assign stall    = out_valid_q && !out_ready;
  assign in_ready = !stall;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign vld_in[k] = in_valid;
      assign sel_in[k] = sel;
      assign c_in[k]   = sel;
      assign a_in[k]   = A;
      assign b_in[k]   = B;
      assign s_in[k]   = '0;
    end else begin : g_body
      assign vld_in[k] = vld_q[k-1];
      assign sel_in[k] = sel_q[k-1];
      assign c_in[k]   = c_q[k-1];
      assign a_in[k]   = a_q[k-1];
      assign b_in[k]   = b_q[k-1];
      assign s_in[k]   = s_q[k-1];
    end

    add_sub_chunk #(
      .CHUNK(CHUNK)
    ) u_chunk (
      .a_i   (a_in[k][k*CHUNK +: CHUNK]),
      .b_i   (b_in[k][k*CHUNK +: CHUNK]),
      .cin_i (c_in[k]),
      .sel_i (sel_in[k]),
      .s_o   (ch_s[k]),
      .cout_o(ch_c[k])
    );
  end

  // Merge each stage's freshly resolved chunk into the sum carried forward
  always_comb begin
    for (int k = 0; k < int'(STAGES); k++) begin
      s_d[k] = s_in[k];
      s_d[k][k*CHUNK +: CHUNK] = ch_s[k];
    end
  end

  assign a_msb  = a_in[LAST][WIDTH-1];
  assign bp_msb = b_in[LAST][WIDTH-1] ^ sel_in[LAST];
  assign ovf_d  = (a_msb == bp_msb) && (s_d[LAST][WIDTH-1] != a_msb);

`ifdef ADD_SUB_SAT_EN
  logic [MaxWidth-1:0] lim;
  assign lim   = signed_limit(WIDTH, a_msb);
  assign res_d = ovf_d ? lim[WIDTH-1:0] : s_d[LAST];
`else
  assign res_d = s_d[LAST];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      sel_q <= '0;
      c_q   <= '0;
      for (int k = 0; k < int'(NPIPE); k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else if (!stall) begin
      for (int k = 0; k < int'(STAGES) - 1; k++) begin
        vld_q[k] <= vld_in[k];
        sel_q[k] <= sel_in[k];
        c_q[k]   <= ch_c[k];
        a_q[k]   <= a_in[k];
        b_q[k]   <= b_in[k];
        s_q[k]   <= s_d[k];
      end
      out_valid_q <= vld_in[LAST];
      sum_q       <= res_d;
      cout_q      <= ch_c[LAST];
      ovf_q       <= ovf_d;
      zero_q      <= (res_d == '0);
    end
  end

  assign out_valid = out_valid_q;
  assign Sum       = sum_q;
  assign Cout      = cout_q;
  assign Ovf       = ovf_q;
  assign Zero      = zero_q;

endmodule

// File: tb/tb_add_sub_pipe.sv
// Directed bench for add_sub_pipe: 16-bit/4-stage table and handshake sequences,
// plus an exhaustive 4-bit/2-stage sweep.
module tb_add_sub_pipe;
  import add_sub_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, sel, out_valid, out_ready, cout, ovf, zero;
  logic [15:0] a, b, sum;

  logic       in_valid4, in_ready4, sel4, out_valid4, out_ready4, cout4, ovf4, zero4;
  logic [3:0] a4, b4, sum4;

  add_sub_pipe #(.WIDTH(16), .STAGES(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .A(a), .B(b), .sel(sel),
    .out_valid(out_valid), .out_ready(out_ready), .Sum(sum), .Cout(cout), .Ovf(ovf),
    .Zero(zero)
  );

  add_sub_pipe #(.WIDTH(4), .STAGES(2)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .A(a4), .B(b4),
    .sel(sel4), .out_valid(out_valid4), .out_ready(out_ready4), .Sum(sum4), .Cout(cout4),
    .Ovf(ovf4), .Zero(zero4)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: returns {zero, ovf, cout, sum} for a w-bit operation
  function automatic logic [18:0] model(input int w, input logic [15:0] x, input logic [15:0] y,
                                        input logic s);
    logic [31:0] mask, bx, full, sm;
    logic        am, bm, rm, c, o;
    mask = (32'd1 << w) - 32'd1;
    bx   = s ? (~{16'd0, y} & mask) : ({16'd0, y} & mask);
    full = ({16'd0, x} & mask) + bx + {31'd0, s};
    sm   = full & mask;
    c    = full[w];
    am   = x[w-1];
    bm   = bx[w-1];
    rm   = sm[w-1];
    o    = (am == bm) && (rm != am);
`ifdef ADD_SUB_SAT_EN
    if (o) sm = am ? (32'd1 << (w - 1)) : (mask >> 1);
`endif
    return {(sm == 32'd0), o, c, sm[15:0]};
  endfunction

  typedef struct {
    logic [15:0] a, b;
    logic        sel;
    logic [15:0] sum, sum_sat;
    logic        cout, ovf, zero, zero_sat;
  } vec_t;

  typedef struct {
    logic [18:0] exp;
    int          cyc;
  } exp_t;

  vec_t        tbl[9];
  logic [18:0] expq[$];
  exp_t        expq4[$];

  initial begin
    logic [15:0] esum, held;
    logic        ezero;
    logic [18:0] e;
    exp_t        e4;
    int          lat, sent, got, idx, got4;

    tbl[0] = '{16'hFFFF, 16'h0001, OP_ADD, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[1] = '{16'h7FFF, 16'h0001, OP_ADD, 16'h8000, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{16'h0003, 16'h0005, OP_SUB, 16'hFFFE, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{16'h8000, 16'h0001, OP_SUB, 16'h7FFF, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{16'h1234, 16'h4321, OP_ADD, 16'h5555, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{16'h5555, 16'h5555, OP_SUB, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[6] = '{16'h8000, 16'h8000, OP_ADD, 16'h0000, 16'h8000, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[7] = '{16'h0000, 16'h0001, OP_SUB, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[8] = '{16'h00F0, 16'h0F10, OP_ADD, 16'h1000, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; sel = OP_ADD;
    in_valid4 = 1'b0; out_ready4 = 1'b1; a4 = '0; b4 = '0; sel4 = OP_ADD;
    repeat (3) tick();
    rst = 1'b0;

    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset Sum", {16'd0, sum}, 32'd0);
    check("reset Cout", {31'd0, cout}, 32'd0);
    check("reset Ovf", {31'd0, ovf}, 32'd0);
    check("reset Zero", {31'd0, zero}, 32'd0);
    check("reset in_ready", {31'd0, in_ready}, 32'd1);

    // Single beats from the table, one at a time
    for (int i = 0; i < 9; i++) begin
`ifdef ADD_SUB_SAT_EN
      esum = tbl[i].sum_sat; ezero = tbl[i].zero_sat;
`else
      esum = tbl[i].sum;     ezero = tbl[i].zero;
`endif
      in_valid = 1'b1; a = tbl[i].a; b = tbl[i].b; sel = tbl[i].sel;
      tick();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin
        tick();
        lat++;
      end
      check($sformatf("v%0d latency", i), lat, 32'd4);
      check($sformatf("v%0d Sum", i), {16'd0, sum}, {16'd0, esum});
      check($sformatf("v%0d Cout", i), {31'd0, cout}, {31'd0, tbl[i].cout});
      check($sformatf("v%0d Ovf", i), {31'd0, ovf}, {31'd0, tbl[i].ovf});
      check($sformatf("v%0d Zero", i), {31'd0, zero}, {31'd0, ezero});
      tick();
    end

    // Back-pressure: 8 beats back-to-back, out_ready low for cycles 6..8
    sent = 0; got = 0; held = '0;
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      out_ready = !(cyc >= 6 && cyc <= 8);
      if (sent < 8) begin
        in_valid = 1'b1;
        a   = 16'(sent) * 16'h1111;
        b   = 16'(sent + 1) * 16'h0101;
        sel = sent[0];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (!out_ready) begin
        check($sformatf("bp in_ready c%0d", cyc), {31'd0, in_ready}, 32'd0);
        if (cyc == 6) held = sum;
        else check($sformatf("bp hold c%0d", cyc), {16'd0, sum}, {16'd0, held});
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          check("bp unexpected beat", {31'd0, out_valid}, 32'd0);
        end else begin
          e = expq.pop_front();
          check($sformatf("bp beat %0d", got), {13'd0, zero, ovf, cout, sum}, {13'd0, e});
        end
        got++;
      end
      if (in_valid && in_ready) begin
        expq.push_back(model(16, a, b, sel));
        sent++;
      end
      tick();
    end
    check("bp beats received", got, 32'd8);
    out_ready = 1'b1; in_valid = 1'b0;
    repeat (2) tick();

    // Reset mid-flight: three beats in the pipe are discarded
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = 16'h0011 * 16'(i + 1); b = 16'h0002; sel = OP_ADD;
      tick();
    end
    in_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("flush out_valid c%0d", i), {31'd0, out_valid}, 32'd0);
      tick();
    end
    in_valid = 1'b1; a = 16'h0100; b = 16'h0023; sel = OP_ADD;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
    check("post-reset latency", lat, 32'd4);
    check("post-reset Sum", {16'd0, sum}, 32'h0123);
    tick();

    // Exhaustive 4-bit sweep, streamed one beat per cycle
    idx = 0; got4 = 0;
    for (int cyc = 0; cyc < 540 && got4 < 512; cyc++) begin
      if (out_valid4) begin
        if (expq4.size() == 0) begin
          check("x4 unexpected beat", {31'd0, out_valid4}, 32'd0);
        end else begin
          e4 = expq4.pop_front();
          check($sformatf("x4 beat %0d", got4),
                {8'd0, 3'(cyc - e4.cyc), zero4, ovf4, cout4, 12'd0, sum4},
                {8'd0, 3'd2, e4.exp});
        end
        got4++;
      end
      if (idx < 512) begin
        in_valid4 = 1'b1;
        a4   = idx[3:0];
        b4   = idx[7:4];
        sel4 = idx[8];
        e4.exp = model(4, {12'd0, a4}, {12'd0, b4}, sel4);
        e4.cyc = cyc;
        expq4.push_back(e4);
        idx++;
      end else begin
        in_valid4 = 1'b0;
      end
      tick();
    end
    check("x4 beats received", got4, 32'd512);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
